ad7606_emu: RTL



---
 rtl/ad7606_emu.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ad7606_emu.sv
// Responder-side model of the AD7606 parallel ADC interface.
// Emulates conversion timing, BUSY, FRSTDATA and the 8-channel readout.
module ad7606_emu #(
  parameter int CONV_CYCLES = 200,
  parameter int BUSY_DELAY  = 2,
  parameter int PATTERN     = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ad_reset,
  input  logic         ad_convstab,
  input  logic         ad_cs,
  input  logic         ad_rd,
  input  logic [2:0]   ad_os,
  input  logic [127:0] samp_data,
  output logic [15:0]  ad_data,
  output logic         ad_busy,
  output logic         first_data,
  output logic         conv_overrun,
  output logic [12:0]  conv_cnt
);

  localparam int CW = 24;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_CONV  = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    os_q, os_d;
  logic [127:0]  snap_q, snap_d;
  logic [127:0]  res_q, res_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [15:0]   data_q, data_d;
  logic          first_q, first_d;
  logic          busy_q, busy_d;
  logic          ovr_q, ovr_d;
  logic [12:0]   ccnt_q, ccnt_d;
  logic          convst_q, rd_q;

  logic          convst_rise, rd_fall, done;
  logic [2:0]    os_eff, ptr_eff;
  logic [CW-1:0] conv_len;
  logic [127:0]  pat, rd_src;

  assign convst_rise = ad_convstab & ~convst_q;
  assign rd_fall     = ~ad_rd & rd_q & ~ad_cs;

  assign os_eff   = (os_q == 3'd7) ? 3'd0 : os_q;
  assign conv_len = CW'(CONV_CYCLES) << os_eff;

  always_comb begin
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      pat[i*16 +: 16] = {3'(i), ccnt_q};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    os_d    = os_q;
    snap_d  = snap_q;
    res_d   = res_q;
    busy_d  = busy_q;
    ccnt_d  = ccnt_q;
    ovr_d   = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE, S_READY: begin
        if (convst_rise) begin
          snap_d  = (PATTERN != 0) ? pat : samp_data;
          os_d    = ad_os;
          cnt_d   = CW'(BUSY_DELAY - 1);
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        ovr_d = convst_rise;
        if (cnt_q == '0) begin
          busy_d  = 1'b1;
          cnt_d   = conv_len - CW'(1);
          state_d = S_CONV;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CONV: begin
        ovr_d = convst_rise;
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          res_d   = snap_q;
          ccnt_d  = ccnt_q + 13'd1;
          done    = 1'b1;
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A read landing on the completion edge sees the fresh data at ch1.
  assign ptr_eff = done ? 3'd0 : ptr_q;
  assign rd_src  = done ? snap_q : res_q;

  always_comb begin
    data_d  = data_q;
    first_d = first_q;
    ptr_d   = ptr_q;
    if (ad_cs) begin
      data_d  = 16'h0000;
      first_d = 1'b0;
      ptr_d   = 3'd0;
    end else if (rd_fall) begin
      data_d  = rd_src[{ptr_eff, 4'b0000} +: 16];
      first_d = (ptr_eff == 3'd0);
      ptr_d   = ptr_eff + 3'd1;
    end else if (done) begin
      ptr_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || ad_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      os_q     <= '0;
      snap_q   <= '0;
      res_q    <= '0;
      ptr_q    <= '0;
      data_q   <= '0;
      first_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      ccnt_q   <= '0;
      convst_q <= 1'b1;
      rd_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      os_q     <= os_d;
      snap_q   <= snap_d;
      res_q    <= res_d;
      ptr_q    <= ptr_d;
      data_q   <= data_d;
      first_q  <= first_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      ccnt_q   <= ccnt_d;
      convst_q <= ad_convstab;
      rd_q     <= ad_rd;
    end
  end

  assign ad_data      = data_q;
  assign ad_busy      = busy_q;
  assign first_data   = first_q;
  assign conv_overrun = ovr_q;
  assign conv_cnt     = ccnt_q;

endmodule
